// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave: 7-byte command frames committed atomically to lamp registers.
// Commit is SYNC_STAGES+2 clk after cs_n is first sampled high; strobe-only outputs, no backpressure.
module spi_frame_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RST_MODE    = 8'h00,
    parameter logic [7:0] RST_LINT    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic [7:0] mode,
    output logic [7:0] lint,
    output logic [7:0] color_idx,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] white,
    output logic       frame_stb,
    output logic       frame_err,
    output logic       byte_stb,
    output logic [7:0] rx_byte
);

    typedef enum logic [1:0] {IDLE, RX, COMMIT, DROP} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, warm_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_prev_q, cs_prev_q, armed_q;
    logic                   sck_rise_q, cs_rise_q, cs_fall_q, mosi_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  new_byte;
    logic [7:0]  shadow_q [7];
    logic [7:0]  shadow_d [7];
    logic [7:0]  out_q [7];
    logic [7:0]  out_d [7];
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        frame_stb_q, frame_stb_d;
    logic        frame_err_q, frame_err_d;
    logic        byte_stb_q, byte_stb_d;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // armed_q only sets once a genuine (post-warm-up) high cs_n is seen, so a frame
    // already in progress when reset releases is never picked up mid-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            warm_q      <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            sck_rise_q  <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (warm_q[SYNC_STAGES-1] & cs_s);
            sck_rise_q  <= sck_s & ~sck_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_fall_q   <= armed_q & cs_prev_q & ~cs_s;
            mosi_q      <= mosi_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        rx_byte_d   = rx_byte_q;
        frame_stb_d = 1'b0;
        frame_err_d = 1'b0;
        byte_stb_d  = 1'b0;
        new_byte    = {shift_q, mosi_q};

        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d    = RX;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                end
            end
            RX: begin
                // cs_n rise takes priority over a coincident sck rise
                if (cs_rise_q) begin
                    if (byte_cnt_q == 3'd7 && bit_cnt_q == 3'd0) begin
                        state_d = COMMIT;
                    end else if (byte_cnt_q == 3'd0 && bit_cnt_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (sck_rise_q) begin
                    if (byte_cnt_q == 3'd7) begin
                        state_d     = DROP;
                        frame_err_d = 1'b1;
                    end else begin
                        shift_d   = new_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d            = new_byte;
                            shadow_d[byte_cnt_q] = new_byte;
                            byte_stb_d           = 1'b1;
                            byte_cnt_d           = byte_cnt_q + 3'd1;
                        end
                    end
                end
            end
            COMMIT: begin
                out_d       = shadow_q;
                frame_stb_d = 1'b1;
                state_d     = IDLE;
            end
            DROP: begin
                if (cs_rise_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 3'd0;
            shift_q     <= 7'd0;
            rx_byte_q   <= 8'd0;
            frame_stb_q <= 1'b0;
            frame_err_q <= 1'b0;
            byte_stb_q  <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                shadow_q[i] <= 8'd0;
                out_q[i]    <= 8'd0;
            end
            out_q[0] <= RST_MODE;
            out_q[1] <= RST_LINT;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            frame_stb_q <= frame_stb_d;
            frame_err_q <= frame_err_d;
            byte_stb_q  <= byte_stb_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
        end
    end

    assign mode      = out_q[0];
    assign lint      = out_q[1];
    assign color_idx = out_q[2];
    assign red       = out_q[3];
    assign green     = out_q[4];
    assign blue      = out_q[5];
    assign white     = out_q[6];
    assign frame_stb = frame_stb_q;
    assign frame_err = frame_err_q;
    assign byte_stb  = byte_stb_q;
    assign rx_byte   = rx_byte_q;

endmodule
